iir_biquad_tdm: RTL and testbench
=================================

# iir_biquad_tdm

Time-multiplexed, multi-channel IIR filter built as a cascade of direct-form-I biquad sections sharing one multiply-accumulate unit. It is the parametrised successor to the single-channel direct-form-I filter, adding per-channel state, runtime-writable coefficients, a valid/ready input handshake, rounding, saturation and overflow reporting. It sits between the ADC capture path and the trigger/decimation logic in the analogue front end.

## Interface
- `CHANNELS`, 2: independent channels, each with its own delay-line state.
- `SECTIONS`, 2: cascaded biquads, giving filter order 2·SECTIONS.
- `INPUT_WIDTH`, 12: signed input sample width.
- `OUTPUT_WIDTH`, 16: signed internal sample and output width.
- `COEFF_WIDTH`, 14: signed coefficient width, format Q2.F where F = COEFF_WIDTH−2.
- Clock and reset: one clock (`clk`); reset `rst_n` is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `x_valid` in 1: input sample valid.
- `x_ready` out 1: block idle, sample may be accepted.
- `x_chan` in clog2(CHANNELS): channel of `x`.
- `x` in INPUT_WIDTH: signed input sample.
- `coeff_we` in 1: coefficient write strobe.
- `coeff_addr` in clog2(SECTIONS)+3: {section, idx}; idx 0..4 = b0,b1,b2,a1,a2; idx 5..7 are ignored.
- `coeff_data` in COEFF_WIDTH: coefficient value.
- `coeff_err` out 1: one-cycle pulse when a write is dropped.
- `state_clr` in 1: clear all delay-line state; honoured only when idle.
- `y_valid` out 1: one-cycle output strobe (no backpressure).
- `y_chan` out clog2(CHANNELS): channel of `y`.
- `y` out OUTPUT_WIDTH: signed output.
- `ovf` out 1: sticky saturation flag.
- `ovf_clr` in 1: clears `ovf`.

## Operation
- FSM states: IDLE → MAC (5 cycles, idx 0..4) → WB (1 cycle) → MAC of the next section, or DONE after the last section → IDLE.
- Handshake: a sample is accepted on an edge where `x_valid && x_ready`. `x_ready` is high only in IDLE.
- Input conditioning: `x` is sign-extended and left-aligned to OUTPUT_WIDTH (shifted left by OUTPUT_WIDTH−INPUT_WIDTH).
- Section s, channel c: acc = b0·xin + b1·x1 + b2·x2 − a1·y1 − a2·y2.
  - Products are OUTPUT_WIDTH+COEFF_WIDTH bits; the accumulator carries 3 extra guard bits.
- WB step:
  - res = (acc + 2^(F−1)) >>> F, i.e. round half up.
  - res saturates to [−2^(OUTPUT_WIDTH−1), 2^(OUTPUT_WIDTH−1)−1]; saturation sets `ovf`.
  - Shift state: x2←x1, x1←xin, y2←y1, y1←res.
  - res becomes xin of section s+1.
- State storage: x1, x2, y1, y2 per (channel, section).
- Coefficients are shared by all channels. Writes are applied only in IDLE. A write while busy is dropped and pulses `coeff_err` on the next cycle.
- Reset values:
  - State is zero.
  - Every section's b0 = 2^F (unity); all other coefficients are 0, so the reset filter is a passthrough.
  - `x_ready`=1, `y_valid`=0, `y`=0, `y_chan`=0, `ovf`=0, `coeff_err`=0.
- `state_clr` in IDLE zeroes all state within one cycle and holds `x_ready` low for that cycle. Coefficients are untouched.
- Simultaneous `ovf_clr` and a saturation event: set wins.
- Simultaneous `state_clr` and `x_valid` in IDLE: the clear wins and the sample is not accepted.
- An `x_chan` value ≥ CHANNELS: the sample is accepted and discarded; no `y_valid` is produced.
- Reset asserted mid-operation aborts immediately: no `y_valid` is produced and all state and coefficients return to reset values.

## Timing
- Acceptance edge E0.
- `y_valid`, `y` and `y_chan` are registered and asserted at edge E0+6·SECTIONS, which is 12 cycles at defaults. `x_ready` rises on the same edge.
- The next sample can be accepted no earlier than E0+6·SECTIONS+1. Throughput is one sample per 6·SECTIONS+1 cycles.
- `y` holds its value until the next `y_valid`.
- A coefficient written at edge T is used by a sample accepted at T+1 or later.

## Structure
- Package `iir_pkg` holds:
  - coefficient index constants (`IDX_B0`..`IDX_A2`);
  - the FSM state encoding;
  - functions for the F fractional-bit count and the accumulator width.
- Sub-module `iir_mac`: signed multiply, accumulate/subtract, and round-and-saturate with an overflow output.
- State and coefficient storage are register arrays in the top level.

## Test plan
- Reset passthrough: ch0 `x`=1024 → `y`=16384 with `y_chan`=0, exactly 12 cycles after acceptance; `ovf`=0.
- Gain: write section 0 b0=2048 (0.5), then `x`=1024 → `y`=8192.
- One-pole impulse response, section 0 b0=4096 and a1=−2048: impulse `x`=1024, 0, 0, 0 → `y`=16384, 8192, 4096, 2048.
- Channel independence: interleave a ch0 impulse with ch1 zeros → ch1 outputs stay 0 and the ch0 decay is unchanged; `state_clr` in IDLE then zeroes the ch0 tail.
- Saturation: b0=8191 in both sections, `x`=2047 → `y`=32767 and `ovf`=1. `ovf_clr` clears it; `ovf_clr` in the same cycle as a new saturation leaves `ovf`=1.
- Protocol and reset:
  - A coefficient write while busy → `coeff_err` pulse and the coefficient is unchanged.
  - `rst_n` low at cycle 5 of a sample → no `y_valid`, and the next sample is passed through.

Source files
------------

// File: rtl/iir_biquad_tdm_pkg.sv
// Shared constants, FSM encoding and width helpers for the TDM biquad filter.
package iir_pkg;

  localparam logic [2:0]  IDX_B0   = 3'd0;
  localparam logic [2:0]  IDX_B1   = 3'd1;
  localparam logic [2:0]  IDX_B2   = 3'd2;
  localparam logic [2:0]  IDX_A1   = 3'd3;
  localparam logic [2:0]  IDX_A2   = 3'd4;
  localparam int unsigned NUM_COEF = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_DONE
  } iir_state_t;

  function automatic int unsigned frac_bits(input int unsigned coeff_width);
    return coeff_width - 2;
  endfunction

  function automatic int unsigned acc_width(input int unsigned out_width,
                                            input int unsigned coeff_width);
    return out_width + coeff_width + 3;
  endfunction

endpackage

// File: rtl/iir_biquad_tdm_mac.sv
// Shared multiply-accumulate unit with round-half-up and saturation of the result.
module iir_mac
  import iir_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned COEFF_WIDTH  = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_en,
  input  logic                           i_first,
  input  logic                           i_sub,
  input  logic signed [OUTPUT_WIDTH-1:0] i_sample,
  input  logic signed [COEFF_WIDTH-1:0]  i_coeff,
  output logic signed [OUTPUT_WIDTH-1:0] o_res,
  output logic                           o_sat
);
  localparam int unsigned AW = acc_width(OUTPUT_WIDTH, COEFF_WIDTH);
  localparam int unsigned F  = frac_bits(COEFF_WIDTH);
  localparam int unsigned PW = OUTPUT_WIDTH + COEFF_WIDTH;
  localparam int unsigned RW = AW - F + 1;

  localparam logic signed [AW:0]   HALF = (AW+1)'(longint'(1) << (F - 1));
  localparam logic signed [RW-1:0] SMAX = RW'((longint'(1) << (OUTPUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = -SMAX - RW'(1);

  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_ext;
  logic signed [AW-1:0] w_base;
  logic signed [AW-1:0] r_acc;
  logic signed [AW:0]   w_rnd;
  logic signed [RW-1:0] w_shift;

  assign w_prod     = PW'(i_sample) * PW'(i_coeff);
  assign w_prod_ext = AW'(w_prod);
  assign w_base     = i_first ? '0 : r_acc;
  assign w_rnd      = (AW+1)'(r_acc) + HALF;
  assign w_shift    = RW'(w_rnd >>> F);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_sub ? (w_base - w_prod_ext) : (w_base + w_prod_ext);
    end
  end

  always_comb begin
    o_sat = 1'b0;
    o_res = w_shift[OUTPUT_WIDTH-1:0];
    if (w_shift > SMAX) begin
      o_sat = 1'b1;
      o_res = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    end else if (w_shift < SMIN) begin
      o_sat = 1'b1;
      o_res = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    end
  end

endmodule

// File: rtl/iir_biquad_tdm.sv
// Multi-channel cascaded direct-form-I biquad filter sharing one MAC in time.
module iir_biquad_tdm
  import iir_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SECTIONS     = 2,
  parameter int unsigned INPUT_WIDTH  = 12,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned COEFF_WIDTH  = 14,
  localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned AW  = $clog2(SECTIONS) + 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           x_valid,
  output logic                           x_ready,
  input  logic [CHW-1:0]                 x_chan,
  input  logic signed [INPUT_WIDTH-1:0]  x,
  input  logic                           coeff_we,
  input  logic [AW-1:0]                  coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0]  coeff_data,
  output logic                           coeff_err,
  input  logic                           state_clr,
  output logic                           y_valid,
  output logic [CHW-1:0]                 y_chan,
  output logic signed [OUTPUT_WIDTH-1:0] y,
  output logic                           ovf,
  input  logic                           ovf_clr
);
  localparam int unsigned F  = frac_bits(COEFF_WIDTH);
  localparam int unsigned SW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam logic signed [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1) << F;

  iir_state_t                     r_state;
  logic [2:0]                     r_idx;
  logic [SW-1:0]                  r_sec;
  logic [CHW-1:0]                 r_chan;
  logic                           r_discard;
  logic signed [OUTPUT_WIDTH-1:0] r_xin;

  logic signed [OUTPUT_WIDTH-1:0] r_x1 [CHANNELS][SECTIONS];
  logic signed [OUTPUT_WIDTH-1:0] r_x2 [CHANNELS][SECTIONS];
  logic signed [OUTPUT_WIDTH-1:0] r_y1 [CHANNELS][SECTIONS];
  logic signed [OUTPUT_WIDTH-1:0] r_y2 [CHANNELS][SECTIONS];
  logic signed [COEFF_WIDTH-1:0]  r_coef [SECTIONS][NUM_COEF];

  logic                           r_y_valid;
  logic [CHW-1:0]                 r_y_chan;
  logic signed [OUTPUT_WIDTH-1:0] r_y;
  logic                           r_ovf;
  logic                           r_coeff_err;

  logic [CHW-1:0]                 w_ch;
  logic                           w_mac_en;
  logic                           w_first;
  logic                           w_sub;
  logic signed [OUTPUT_WIDTH-1:0] w_operand;
  logic signed [COEFF_WIDTH-1:0]  w_coeff;
  logic signed [OUTPUT_WIDTH-1:0] w_res;
  logic                           w_sat;

  // Discarded samples still walk the FSM; reads are steered to a legal channel.
  assign w_ch     = r_discard ? '0 : r_chan;
  assign w_mac_en = (r_state == S_MAC);
  assign w_first  = (r_idx == IDX_B0);
  assign w_sub    = (r_idx == IDX_A1) || (r_idx == IDX_A2);

  always_comb begin
    w_operand = r_xin;
    w_coeff   = r_coef[r_sec][IDX_B0];
    case (r_idx)
      IDX_B1: begin
        w_operand = r_x1[w_ch][r_sec];
        w_coeff   = r_coef[r_sec][IDX_B1];
      end
      IDX_B2: begin
        w_operand = r_x2[w_ch][r_sec];
        w_coeff   = r_coef[r_sec][IDX_B2];
      end
      IDX_A1: begin
        w_operand = r_y1[w_ch][r_sec];
        w_coeff   = r_coef[r_sec][IDX_A1];
      end
      IDX_A2: begin
        w_operand = r_y2[w_ch][r_sec];
        w_coeff   = r_coef[r_sec][IDX_A2];
      end
      default: ;
    endcase
  end

  iir_mac #(
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .COEFF_WIDTH  (COEFF_WIDTH)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_mac_en),
    .i_first  (w_first),
    .i_sub    (w_sub),
    .i_sample (w_operand),
    .i_coeff  (w_coeff),
    .o_res    (w_res),
    .o_sat    (w_sat)
  );

  // The last section's write-back runs in DONE so the output lands with x_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_sec       <= '0;
      r_chan      <= '0;
      r_discard   <= 1'b0;
      r_xin       <= '0;
      r_y_valid   <= 1'b0;
      r_y_chan    <= '0;
      r_y         <= '0;
      r_ovf       <= 1'b0;
      r_coeff_err <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned s = 0; s < SECTIONS; s++) begin
          r_x1[c][s] <= '0;
          r_x2[c][s] <= '0;
          r_y1[c][s] <= '0;
          r_y2[c][s] <= '0;
        end
      end
      for (int unsigned s = 0; s < SECTIONS; s++) begin
        for (int unsigned k = 0; k < NUM_COEF; k++) begin
          r_coef[s][k] <= (k == 0) ? UNITY : '0;
        end
      end
    end else begin
      r_y_valid   <= 1'b0;
      r_coeff_err <= 1'b0;
      if (ovf_clr) begin
        r_ovf <= 1'b0;
      end

      if (coeff_we) begin
        if (r_state != S_IDLE) begin
          r_coeff_err <= 1'b1;
        end else begin
          for (int unsigned s = 0; s < SECTIONS; s++) begin
            for (int unsigned k = 0; k < NUM_COEF; k++) begin
              if (coeff_addr == AW'(s * 8 + k)) begin
                r_coef[s][k] <= coeff_data;
              end
            end
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (state_clr) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              for (int unsigned s = 0; s < SECTIONS; s++) begin
                r_x1[c][s] <= '0;
                r_x2[c][s] <= '0;
                r_y1[c][s] <= '0;
                r_y2[c][s] <= '0;
              end
            end
          end else if (x_valid) begin
            r_xin     <= OUTPUT_WIDTH'(x) << (OUTPUT_WIDTH - INPUT_WIDTH);
            r_chan    <= x_chan;
            r_discard <= (32'(x_chan) >= CHANNELS);
            r_sec     <= '0;
            r_idx     <= IDX_B0;
            r_state   <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_idx == IDX_A2) begin
            r_idx   <= IDX_B0;
            r_state <= (r_sec == SW'(SECTIONS - 1)) ? S_DONE : S_WB;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_WB, S_DONE: begin
          if (!r_discard) begin
            r_x2[w_ch][r_sec] <= r_x1[w_ch][r_sec];
            r_x1[w_ch][r_sec] <= r_xin;
            r_y2[w_ch][r_sec] <= r_y1[w_ch][r_sec];
            r_y1[w_ch][r_sec] <= w_res;
            if (w_sat) begin
              r_ovf <= 1'b1;
            end
          end
          r_xin <= w_res;
          if (r_state == S_DONE) begin
            r_state <= S_IDLE;
            if (!r_discard) begin
              r_y_valid <= 1'b1;
              r_y       <= w_res;
              r_y_chan  <= r_chan;
            end
          end else begin
            r_sec   <= r_sec + SW'(1);
            r_state <= S_MAC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_ready   = (r_state == S_IDLE) && !state_clr;
  assign y_valid   = r_y_valid;
  assign y_chan    = r_y_chan;
  assign y         = r_y;
  assign ovf       = r_ovf;
  assign coeff_err = r_coeff_err;

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Directed, table-driven bench for iir_biquad_tdm with hand-computed expectations.
module tb_iir_biquad_tdm;
  localparam int unsigned CH  = 2;
  localparam int unsigned SEC = 2;
  localparam int unsigned IW  = 12;
  localparam int unsigned OW  = 16;
  localparam int unsigned CW  = 14;
  localparam int unsigned CHW = 1;
  localparam int unsigned AW  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 x_valid = 1'b0;
  logic                 x_ready;
  logic [CHW-1:0]       x_chan = '0;
  logic signed [IW-1:0] x = '0;
  logic                 coeff_we = 1'b0;
  logic [AW-1:0]        coeff_addr = '0;
  logic signed [CW-1:0] coeff_data = '0;
  logic                 coeff_err;
  logic                 state_clr = 1'b0;
  logic                 y_valid;
  logic [CHW-1:0]       y_chan;
  logic signed [OW-1:0] y;
  logic                 ovf;
  logic                 ovf_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  iir_biquad_tdm #(
    .CHANNELS     (CH),
    .SECTIONS     (SEC),
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .COEFF_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_chan     (x_chan),
    .x          (x),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .coeff_err  (coeff_err),
    .state_clr  (state_clr),
    .y_valid    (y_valid),
    .y_chan     (y_chan),
    .y          (y),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit clr;
    bit wr;
    int addr;
    int data;
    bit send;
    int ch;
    int xv;
    int ey;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wr_coef(input int addr, input int data);
    coeff_addr = AW'(addr);
    coeff_data = CW'(data);
    coeff_we   = 1'b1;
    @(posedge clk); #1;
    coeff_we   = 1'b0;
    check("idle_write_no_err", int'(coeff_err), 0);
  endtask

  task automatic do_clr();
    state_clr = 1'b1;
    #1;
    check("clr_ready_low", int'(x_ready), 0);
    @(posedge clk); #1;
    state_clr = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!x_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic send(input int ch, input int xv, output int yv, output int ych, output int lat);
    wait_ready();
    x_chan  = CHW'(ch);
    x       = IW'(xv);
    x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    lat = 0;
    repeat (40) begin
      @(posedge clk); #1;
      lat++;
      if (y_valid) break;
    end
    if (!y_valid) lat = -1;
    yv  = int'(y);
    ych = int'(y_chan);
  endtask

  task automatic count_valid(input int cycles, output int nv);
    nv = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (y_valid) nv++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int yv, ych, lat, nv;

    tbl[0]  = '{0, 0, 0, 0,     1, 1, -512, -8192};
    tbl[1]  = '{0, 1, 0, 2048,  1, 0, 1024, 8192};
    tbl[2]  = '{0, 1, 0, 384,   1, 0, 1,    2};
    tbl[3]  = '{0, 0, 0, 0,     1, 0, -1,   -1};
    tbl[4]  = '{0, 1, 0, 4096,  0, 0, 0,    0};
    tbl[5]  = '{1, 1, 3, -2048, 1, 0, 1024, 16384};
    tbl[6]  = '{0, 0, 0, 0,     1, 1, 0,    0};
    tbl[7]  = '{0, 0, 0, 0,     1, 0, 0,    8192};
    tbl[8]  = '{0, 0, 0, 0,     1, 1, 0,    0};
    tbl[9]  = '{0, 0, 0, 0,     1, 0, 0,    4096};
    tbl[10] = '{0, 0, 0, 0,     1, 0, 0,    2048};
    tbl[11] = '{1, 0, 0, 0,     1, 0, 0,    0};
    tbl[12] = '{0, 0, 0, 0,     1, 1, 0,    0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_x_ready", int'(x_ready), 1);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_y", int'(y), 0);
    check("rst_y_chan", int'(y_chan), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_coeff_err", int'(coeff_err), 0);

    send(0, 1024, yv, ych, lat);
    check("pass_y", yv, 16384);
    check("pass_chan", ych, 0);
    check("pass_lat", lat, 12);
    check("pass_ovf", int'(ovf), 0);
    @(posedge clk); #1;
    check("pass_valid_pulse", int'(y_valid), 0);
    check("pass_y_hold", int'(y), 16384);

    foreach (tbl[i]) begin
      if (tbl[i].clr) do_clr();
      if (tbl[i].wr) wr_coef(tbl[i].addr, tbl[i].data);
      if (tbl[i].send) begin
        send(tbl[i].ch, tbl[i].xv, yv, ych, lat);
        check($sformatf("row%0d_y", i), yv, tbl[i].ey);
        check($sformatf("row%0d_chan", i), ych, tbl[i].ch);
        check($sformatf("row%0d_lat", i), lat, 12);
      end
    end

    wr_coef(3, 0);
    wr_coef(0, 8191);
    wr_coef(8, 8191);
    send(0, 2047, yv, ych, lat);
    check("sat_pos_y", yv, 32767);
    check("sat_ovf_set", int'(ovf), 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", int'(ovf), 0);

    wait_ready();
    x_chan  = 1'b0;
    x       = IW'(2047);
    x_valid = 1'b1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("ovf_clr_midrun", int'(ovf), 0);
    repeat (5) @(posedge clk);
    #1;
    check("setclr_valid", int'(y_valid), 1);
    check("setclr_ovf_wins", int'(ovf), 1);
    ovf_clr = 1'b0;

    send(1, -2048, yv, ych, lat);
    check("sat_neg_y", yv, -32768);
    check("sat_neg_chan", ych, 1);

    wr_coef(0, 2048);
    wr_coef(8, 4096);
    wait_ready();
    x_chan  = 1'b0;
    x       = IW'(1024);
    x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    coeff_addr = AW'(0);
    coeff_data = CW'(100);
    coeff_we   = 1'b1;
    @(posedge clk); #1;
    coeff_we   = 1'b0;
    check("busy_err_pulse", int'(coeff_err), 1);
    @(posedge clk); #1;
    check("busy_err_one_cycle", int'(coeff_err), 0);
    lat = 0;
    while (!y_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy_sample_valid", int'(y_valid), 1);
    check("busy_sample_y", int'(y), 8192);
    send(0, 1024, yv, ych, lat);
    check("busy_coef_unchanged", yv, 8192);

    wait_ready();
    state_clr = 1'b1;
    x_valid   = 1'b1;
    x         = IW'(1024);
    @(posedge clk); #1;
    state_clr = 1'b0;
    x_valid   = 1'b0;
    count_valid(15, nv);
    check("clr_beats_valid", nv, 0);

    wait_ready();
    x_chan  = 1'b1;
    x       = IW'(1024);
    x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", int'(x_ready), 1);
    check("midrst_ovf", int'(ovf), 0);
    check("midrst_y", int'(y), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_valid(15, nv);
    check("midrst_no_valid", nv, 0);
    send(0, 1024, yv, ych, lat);
    check("post_rst_pass_y", yv, 16384);
    check("post_rst_lat", lat, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
